// File: rtl/bs_wqe_wrr_sched.sv
// bs_wqe_wrr_sched: weighted round-robin read scheduler for the per-slot
// bandwidth-sensitive WQE FIFOs. Issues one-hot single-cycle FIFO reads,
// captures the returned WQE and hands it downstream over valid/ready.
// Optional feature macro: BS_SCHED_STATS_EN (per-slot 32-bit grant counters).
module bs_wqe_wrr_sched #(
  parameter int unsigned PWQE_SLOT_NUM  = 4,
  parameter int unsigned SLOT_W         = 2,
  parameter int unsigned WQE_WIDTH      = 512,
  parameter int unsigned WEIGHT_WIDTH   = 4,
  parameter int unsigned DEFAULT_WEIGHT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PWQE_SLOT_NUM-1:0] i_bs_fifo_empty,
  output logic [PWQE_SLOT_NUM-1:0] o_bs_fifo_rd,
  input  logic                     i_bs_wqe_val,
  input  logic [WQE_WIDTH-1:0]     i_bs_wqe,
  output logic                     o_wqe_val,
  output logic [WQE_WIDTH-1:0]     o_wqe,
  output logic [SLOT_W-1:0]        o_wqe_slot,
  input  logic                     i_wqe_rdy,
  input  logic                     i_wgt_wr,
  input  logic [SLOT_W-1:0]        i_wgt_slot,
  input  logic [WEIGHT_WIDTH-1:0]  i_wgt_data,
  output logic                     o_err,
  input  logic [SLOT_W-1:0]        i_stat_slot,
  output logic [31:0]              o_stat_cnt
);

  localparam int unsigned STAT_W = 32;

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_RD   = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [SLOT_W-1:0]         ptr_q, ptr_d;
  logic [WEIGHT_WIDTH-1:0]   credit_q, credit_d;
  logic [SLOT_W-1:0]         gnt_slot_q, gnt_slot_d;
  logic [WEIGHT_WIDTH-1:0]   weight_q [PWQE_SLOT_NUM];

  logic [PWQE_SLOT_NUM-1:0]  rd_d;
  logic                      wqe_val_d;
  logic [WQE_WIDTH-1:0]      wqe_d;
  logic [SLOT_W-1:0]         wqe_slot_d;
  logic                      err_d;

  logic [PWQE_SLOT_NUM-1:0]  elig;
  logic                      ptr_hit;
  logic                      srch_found;
  logic [SLOT_W-1:0]         srch_slot;
  logic                      arb_gnt;
  logic [SLOT_W-1:0]         arb_slot;

  // Slot is a candidate when its FIFO holds data and its weight is non-zero
  always_comb begin
    elig = '0;
    for (int unsigned s = 0; s < PWQE_SLOT_NUM; s++) begin
      elig[s] = ~i_bs_fifo_empty[s] && (weight_q[s] != '0);
    end
  end

  // First eligible slot after ptr, wrapping round to ptr itself last
  always_comb begin
    logic [SLOT_W-1:0] idx;
    idx        = '0;
    srch_found = 1'b0;
    srch_slot  = ptr_q;
    for (int unsigned k = 1; k <= PWQE_SLOT_NUM; k++) begin
      idx = SLOT_W'((32'(ptr_q) + k) % PWQE_SLOT_NUM);
      if (!srch_found && elig[idx]) begin
        srch_found = 1'b1;
        srch_slot  = idx;
      end
    end
  end

  // Stay on the current slot while it has credit, otherwise move on
  always_comb begin
    ptr_hit  = elig[ptr_q] && (credit_q != '0);
    arb_gnt  = ptr_hit || srch_found;
    arb_slot = ptr_hit ? ptr_q : srch_slot;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    credit_d   = credit_q;
    gnt_slot_d = gnt_slot_q;
    rd_d       = '0;
    wqe_val_d  = o_wqe_val;
    wqe_d      = o_wqe;
    wqe_slot_d = o_wqe_slot;
    err_d      = o_err;

    unique case (state_q)
      ST_ARB: begin
        if (i_bs_wqe_val) begin
          err_d = 1'b1;
        end
        if (ptr_hit) begin
          credit_d = credit_q - WEIGHT_WIDTH'(1);
        end else if (srch_found) begin
          ptr_d    = srch_slot;
          credit_d = weight_q[srch_slot] - WEIGHT_WIDTH'(1);
        end
        if (arb_gnt) begin
          rd_d       = PWQE_SLOT_NUM'(1) << arb_slot;
          gnt_slot_d = arb_slot;
          state_d    = ST_RD;
        end
      end
      ST_RD: begin
        if (i_bs_wqe_val) begin
          err_d = 1'b1;
        end
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_bs_wqe_val) begin
          wqe_d      = i_bs_wqe;
          wqe_slot_d = gnt_slot_q;
          wqe_val_d  = 1'b1;
          state_d    = ST_HOLD;
        end else begin
          err_d   = 1'b1;
          state_d = ST_ARB;
        end
      end
      ST_HOLD: begin
        if (i_bs_wqe_val) begin
          err_d = 1'b1;
        end
        if (i_wqe_rdy) begin
          wqe_val_d = 1'b0;
          state_d   = ST_ARB;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // State, arbitration context and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ARB;
      ptr_q        <= '0;
      credit_q     <= '0;
      gnt_slot_q   <= '0;
      o_bs_fifo_rd <= '0;
      o_wqe_val    <= 1'b0;
      o_wqe        <= '0;
      o_wqe_slot   <= '0;
      o_err        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      credit_q     <= credit_d;
      gnt_slot_q   <= gnt_slot_d;
      o_bs_fifo_rd <= rd_d;
      o_wqe_val    <= wqe_val_d;
      o_wqe        <= wqe_d;
      o_wqe_slot   <= wqe_slot_d;
      o_err        <= err_d;
    end
  end

  // Run-time weight table; new values are only picked up at credit reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < PWQE_SLOT_NUM; s++) begin
        weight_q[s] <= WEIGHT_WIDTH'(DEFAULT_WEIGHT);
      end
    end else if (i_wgt_wr) begin
      weight_q[i_wgt_slot] <= i_wgt_data;
    end
  end

`ifdef BS_SCHED_STATS_EN
  logic [STAT_W-1:0] stat_cnt_q [PWQE_SLOT_NUM];

  // Per-slot grant counters, free-running with natural wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < PWQE_SLOT_NUM; s++) begin
        stat_cnt_q[s] <= '0;
      end
    end else if ((state_q == ST_ARB) && arb_gnt) begin
      stat_cnt_q[arb_slot] <= stat_cnt_q[arb_slot] + STAT_W'(1);
    end
  end

  assign o_stat_cnt = stat_cnt_q[i_stat_slot];
`else
  logic unused_stat_slot;

  assign unused_stat_slot = ^i_stat_slot;
  assign o_stat_cnt       = '0;
`endif

endmodule
